// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: stall hold, flush and load-use bubble insertion, load-use stall request.
// Define ID_EX_PERF_CNT_EN to build the bubble/flush event counters; otherwise they read as zero.
package rv32i_types_pkg;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef struct packed {
    rv32i_opcode opcode;
    logic [2:0]  aluop;
    logic [2:0]  cmpop;
    logic [2:0]  immmux_sel;
    logic        alumux1_sel;
    logic [2:0]  alumux2_sel;
    logic [3:0]  regfilemux_sel;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic        load_regfile;
    logic [2:0]  funct3;
  } rv32i_control_word;

endpackage

module id_ex_stage_reg
  import rv32i_types_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int PERF_CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_in,
  input  logic                  flush,
  input  logic                  id_valid,
  input  rv32i_control_word     id_ctrl,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [4:0]            id_rs1,
  input  logic [4:0]            id_rs2,
  input  logic [4:0]            id_rd,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [XLEN-1:0]       id_imm,
  output logic                  ex_valid,
  output rv32i_control_word     ex_ctrl,
  output logic [XLEN-1:0]       ex_pc,
  output logic [XLEN-1:0]       ex_rs1_data,
  output logic [XLEN-1:0]       ex_rs2_data,
  output logic [XLEN-1:0]       ex_imm,
  output logic [4:0]            ex_rs1,
  output logic [4:0]            ex_rs2,
  output logic [4:0]            ex_rd,
  output logic                  load_use_stall,
  output logic [PERF_CNT_W-1:0] bubble_cnt,
  output logic [PERF_CNT_W-1:0] flush_cnt
);

  logic              valid_q, valid_d;
  rv32i_control_word ctrl_q, ctrl_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]   imm_q, imm_d;
  logic [4:0]        rs1_q, rs1_d;
  logic [4:0]        rs2_q, rs2_d;
  logic [4:0]        rd_q, rd_d;

  logic uses_rs1;
  logic uses_rs2;
  logic hazard;

  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (id_ctrl.opcode)
      op_jalr, op_load, op_imm, op_csr: uses_rs1 = 1'b1;
      op_br, op_store, op_reg: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      default: ;
    endcase
  end

  // CSR ops set mem_read, so they count as loads for the hazard check.
  assign hazard = valid_q && ctrl_q.mem_read && ctrl_q.load_regfile &&
                  (rd_q != 5'd0) && id_valid &&
                  ((uses_rs1 && (id_rs1 == rd_q)) || (uses_rs2 && (id_rs2 == rd_q)));

  assign load_use_stall = hazard && !stall_in && !flush;

  always_comb begin
    valid_d    = valid_q;
    ctrl_d     = ctrl_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    if (!stall_in) begin
      if (flush || hazard) begin
        valid_d    = 1'b0;
        ctrl_d     = '0;
        pc_d       = '0;
        rs1_data_d = '0;
        rs2_data_d = '0;
        imm_d      = '0;
        rs1_d      = '0;
        rs2_d      = '0;
        rd_d       = '0;
      end else begin
        valid_d    = id_valid;
        ctrl_d     = id_ctrl;
        pc_d       = id_pc;
        rs1_data_d = id_rs1_data;
        rs2_data_d = id_rs2_data;
        imm_d      = id_imm;
        rs1_d      = id_rs1;
        rs2_d      = id_rs2;
        rd_d       = id_rd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= 1'b0;
      ctrl_q     <= '0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
    end else begin
      valid_q    <= valid_d;
      ctrl_q     <= ctrl_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_ctrl     = ctrl_q;
  assign ex_pc       = pc_q;
  assign ex_rs1_data = rs1_data_q;
  assign ex_rs2_data = rs2_data_q;
  assign ex_imm      = imm_q;
  assign ex_rs1      = rs1_q;
  assign ex_rs2      = rs2_q;
  assign ex_rd       = rd_q;

`ifdef ID_EX_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] bubble_cnt_q;
  logic [PERF_CNT_W-1:0] flush_cnt_q;
  logic [PERF_CNT_W-1:0] cnt_one;

  assign cnt_one = {{(PERF_CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if (load_use_stall) bubble_cnt_q <= bubble_cnt_q + cnt_one;
      if (flush && !stall_in) flush_cnt_q <= flush_cnt_q + cnt_one;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;
`else
  assign bubble_cnt = '0;
  assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed pipeline scenarios plus randomized traffic
// compared against a slot-level reference model of the EX register.
module tb_id_ex_stage_reg;
   import rv32i_types_pkg::*;

   localparam int XLEN = 32;
   localparam int CW = 32;

   typedef struct packed {
      logic              valid;
      rv32i_control_word ctrl;
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   rs1d;
      logic [XLEN-1:0]   rs2d;
      logic [XLEN-1:0]   imm;
      logic [4:0]        rs1;
      logic [4:0]        rs2;
      logic [4:0]        rd;
   } exSlot_t;

   logic clk;
   logic rst;
   logic stallIn, flushIn, idValid;
   rv32i_control_word idCtrl;
   logic [XLEN-1:0] idPc, idRs1Data, idRs2Data, idImm;
   logic [4:0] idRs1, idRs2, idRd;

   logic exValid;
   rv32i_control_word exCtrl;
   logic [XLEN-1:0] exPc, exRs1Data, exRs2Data, exImm;
   logic [4:0] exRs1, exRs2, exRd;
   logic loadUseStall;
   logic [CW-1:0] bubbleCnt, flushCnt;

   int checks = 0;
   int failures = 0;

   exSlot_t slot;
   logic [CW-1:0] expBubble;
   logic [CW-1:0] expFlush;

   rv32i_opcode opList [10] = '{op_lui, op_auipc, op_jal, op_jalr, op_br,
                               op_load, op_store, op_imm, op_reg, op_csr};

   id_ex_stage_reg #(.XLEN(XLEN), .PERF_CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .stall_in(stallIn), .flush(flushIn),
      .id_valid(idValid), .id_ctrl(idCtrl), .id_pc(idPc),
      .id_rs1(idRs1), .id_rs2(idRs2), .id_rd(idRd),
      .id_rs1_data(idRs1Data), .id_rs2_data(idRs2Data), .id_imm(idImm),
      .ex_valid(exValid), .ex_ctrl(exCtrl), .ex_pc(exPc),
      .ex_rs1_data(exRs1Data), .ex_rs2_data(exRs2Data), .ex_imm(exImm),
      .ex_rs1(exRs1), .ex_rs2(exRs2), .ex_rd(exRd),
      .load_use_stall(loadUseStall), .bubble_cnt(bubbleCnt), .flush_cnt(flushCnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkField(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Load-use rule straight from the operand-usage table.
   function automatic logic modelHazard();
      logic r1, r2;
      r1 = idCtrl.opcode inside {op_jalr, op_br, op_load, op_store, op_imm, op_reg, op_csr};
      r2 = idCtrl.opcode inside {op_br, op_store, op_reg};
      return slot.valid && slot.ctrl.mem_read && slot.ctrl.load_regfile && (slot.rd != 5'd0)
             && idValid && ((r1 && idRs1 == slot.rd) || (r2 && idRs2 == slot.rd));
   endfunction

   task automatic checkOutput(input string tag);
      checkField({tag, ".valid"}, 64'(exValid), 64'(slot.valid));
      checkField({tag, ".ctrl"}, 64'(exCtrl), 64'(slot.ctrl));
      checkField({tag, ".pc"}, 64'(exPc), 64'(slot.pc));
      checkField({tag, ".rs1d"}, 64'(exRs1Data), 64'(slot.rs1d));
      checkField({tag, ".rs2d"}, 64'(exRs2Data), 64'(slot.rs2d));
      checkField({tag, ".imm"}, 64'(exImm), 64'(slot.imm));
      checkField({tag, ".idx"}, 64'({exRs1, exRs2, exRd}), 64'({slot.rs1, slot.rs2, slot.rd}));
      checkField({tag, ".bcnt"}, 64'(bubbleCnt), 64'(expBubble));
      checkField({tag, ".fcnt"}, 64'(flushCnt), 64'(expFlush));
   endtask

   // Checks the stall request, clocks one edge, advances the model, then checks EX.
   task automatic stepCycle(input string tag);
      logic haz;
      #1;
      haz = modelHazard();
      checkField({tag, ".lus"}, 64'(loadUseStall), 64'(haz && !stallIn && !flushIn));
      @(posedge clk);
      if (!stallIn) begin
         if (flushIn) begin
            slot = '0;
`ifdef ID_EX_PERF_CNT_EN
            expFlush++;
`endif
         end else if (haz) begin
            slot = '0;
`ifdef ID_EX_PERF_CNT_EN
            expBubble++;
`endif
         end else begin
            slot.valid = idValid;
            slot.ctrl  = idCtrl;
            slot.pc    = idPc;
            slot.rs1d  = idRs1Data;
            slot.rs2d  = idRs2Data;
            slot.imm   = idImm;
            slot.rs1   = idRs1;
            slot.rs2   = idRs2;
            slot.rd    = idRd;
         end
      end
      #1;
      checkOutput(tag);
   endtask

   task automatic applyStimulus(input rv32i_opcode op, input logic mr, input logic lr,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm);
      idValid         = 1'b1;
      idCtrl          = '0;
      idCtrl.opcode   = op;
      idCtrl.mem_read = mr;
      idCtrl.load_regfile = lr;
      idCtrl.aluop    = 3'($urandom);
      idCtrl.funct3   = 3'($urandom);
      idRs1 = rs1;
      idRs2 = rs2;
      idRd  = rd;
      idPc  = pc;
      idImm = imm;
      idRs1Data = $urandom;
      idRs2Data = $urandom;
   endtask

   task automatic randomizeInputs();
      rv32i_opcode op;
      stallIn = ($urandom_range(0, 9) == 0);
      flushIn = ($urandom_range(0, 9) == 0);
      op = opList[$urandom_range(0, 9)];
      idCtrl = rv32i_control_word'({$urandom, $urandom});
      idCtrl.opcode = op;
      idCtrl.mem_read = (op == op_load || op == op_csr) ? ($urandom_range(0, 4) != 0) : 1'b0;
      idCtrl.load_regfile = ($urandom_range(0, 3) != 0);
      idValid = ($urandom_range(0, 4) != 0);
      idRs1 = 5'($urandom_range(0, 3));
      idRs2 = 5'($urandom_range(0, 3));
      idRd  = 5'($urandom_range(0, 3));
      idPc = $urandom;
      idImm = $urandom;
      idRs1Data = $urandom;
      idRs2Data = $urandom;
   endtask

   initial begin
      slot = '0;
      expBubble = '0;
      expFlush = '0;
      rst = 1'b0;
      randomizeInputs();

      // Reset held with random inputs and a running clock.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         randomizeInputs();
         #1;
         checkField("rst.valid", 64'(exValid), 64'(0));
         checkField("rst.ctrl", 64'(exCtrl), 64'(0));
         checkField("rst.lus", 64'(loadUseStall), 64'(0));
         checkField("rst.pc", 64'(exPc), 64'(0));
      end

      // Release and capture ADDI x5,x1,3 on the very next edge.
      @(negedge clk);
      rst = 1'b1;
      stallIn = 1'b0;
      flushIn = 1'b0;
      applyStimulus(op_imm, 1'b0, 1'b1, 5'd1, 5'd0, 5'd5, 32'h60, 32'd3);
      stepCycle("addi");
      checkField("addi.pcK", 64'(exPc), 64'h60);
      checkField("addi.rdK", 64'(exRd), 64'd5);
      checkField("addi.immK", 64'(exImm), 64'd3);
      checkField("addi.validK", 64'(exValid), 64'd1);

      // Load-use: LW x7 then ADD x8,x7,x2 takes exactly one bubble.
      applyStimulus(op_load, 1'b1, 1'b1, 5'd1, 5'd0, 5'd7, 32'h64, 32'd0);
      stepCycle("lw");
      applyStimulus(op_reg, 1'b0, 1'b1, 5'd7, 5'd2, 5'd8, 32'h68, 32'd0);
      #1;
      checkField("lu.stallK", 64'(loadUseStall), 64'd1);
      stepCycle("lu.bubble");
      checkField("lu.bubbleK", 64'(exValid), 64'd0);
      #1;
      checkField("lu.clearK", 64'(loadUseStall), 64'd0);
      stepCycle("lu.add");
      checkField("lu.addRdK", 64'(exRd), 64'd8);
      checkField("lu.addValidK", 64'(exValid), 64'd1);

      // Store data dependency on rs2 also stalls.
      applyStimulus(op_load, 1'b1, 1'b1, 5'd1, 5'd0, 5'd9, 32'h70, 32'd0);
      stepCycle("lw9");
      applyStimulus(op_store, 1'b0, 1'b0, 5'd3, 5'd9, 5'd0, 32'h74, 32'd4);
      #1;
      checkField("sw.stallK", 64'(loadUseStall), 64'd1);
      stepCycle("sw.bubble");
      stepCycle("sw.adv");

      // x0 destination never hazards.
      applyStimulus(op_load, 1'b1, 1'b1, 5'd1, 5'd0, 5'd0, 32'h80, 32'd0);
      stepCycle("lwx0");
      applyStimulus(op_reg, 1'b0, 1'b1, 5'd0, 5'd2, 5'd8, 32'h84, 32'd0);
      #1;
      checkField("x0.stallK", 64'(loadUseStall), 64'd0);
      stepCycle("x0.add");
      checkField("x0.validK", 64'(exValid), 64'd1);

      // LUI uses no source register.
      applyStimulus(op_load, 1'b1, 1'b1, 5'd1, 5'd0, 5'd7, 32'h88, 32'd0);
      stepCycle("lw7b");
      applyStimulus(op_lui, 1'b0, 1'b1, 5'd7, 5'd7, 5'd7, 32'h8c, 32'h1000);
      #1;
      checkField("lui.stallK", 64'(loadUseStall), 64'd0);
      stepCycle("lui");

      // Flush dominates a present hazard.
      applyStimulus(op_load, 1'b1, 1'b1, 5'd1, 5'd0, 5'd7, 32'h90, 32'd0);
      stepCycle("lw7c");
      applyStimulus(op_reg, 1'b0, 1'b1, 5'd7, 5'd2, 5'd8, 32'h94, 32'd0);
      flushIn = 1'b1;
      #1;
      checkField("fl.stallK", 64'(loadUseStall), 64'd0);
      stepCycle("fl");
      checkField("fl.validK", 64'(exValid), 64'd0);
      flushIn = 1'b0;

      // Stall dominates both flush and hazard for three edges.
      applyStimulus(op_load, 1'b1, 1'b1, 5'd1, 5'd0, 5'd7, 32'hA0, 32'd0);
      stepCycle("lw7d");
      applyStimulus(op_reg, 1'b0, 1'b1, 5'd7, 5'd2, 5'd8, 32'hA4, 32'd0);
      stallIn = 1'b1;
      flushIn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         stepCycle("st");
         checkField("st.rdK", 64'(exRd), 64'd7);
         checkField("st.pcK", 64'(exPc), 64'hA0);
      end
      stallIn = 1'b0;
      flushIn = 1'b0;
      stepCycle("st.rel");
      stepCycle("st.adv");

      // Randomized traffic.
      for (int i = 0; i < 300; i++) begin
         randomizeInputs();
         stepCycle("rnd");
      end

      // Asynchronous reset in the middle of activity.
      randomizeInputs();
      #2;
      rst = 1'b0;
      #1;
      slot = '0;
      expBubble = '0;
      expFlush = '0;
      checkField("arst.valid", 64'(exValid), 64'd0);
      checkField("arst.ctrl", 64'(exCtrl), 64'd0);
      checkField("arst.lus", 64'(loadUseStall), 64'd0);
      checkField("arst.bcnt", 64'(bubbleCnt), 64'd0);
      checkField("arst.fcnt", 64'(flushCnt), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 40; i++) begin
         randomizeInputs();
         stepCycle("post");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Pipeline register between decode (control-word generation plus regfile read) and execute.
- Latches the decoded control word, PC, operands, immediate and register indices each cycle.
- Applies global stall, branch-flush and load-use bubble insertion.
- Produces the load-use stall request that freezes the PC and IF/ID registers.

Parameters:
- XLEN, 32, datapath width of pc, rs1/rs2 data and immediate.
- PERF_CNT_W, 32, width of the optional event counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall_in  in  1  global freeze (cache miss); register holds.
- flush  in  1  EX-resolved branch/jump redirect; squash the instruction entering EX.
- id_valid  in  1  decode slot holds a real instruction.
- id_ctrl  in  rv32i_control_word  decoded control word.
- id_pc  in  XLEN  PC of the decoding instruction.
- id_rs1, id_rs2, id_rd  in  5 each  register indices.
- id_rs1_data, id_rs2_data  in  XLEN each  regfile read data.
- id_imm  in  XLEN  immediate already selected per immmux_sel.
- ex_valid  out  1  EX slot valid.
- ex_ctrl  out  rv32i_control_word  registered control word.
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN each  registered fields.
- ex_rs1, ex_rs2, ex_rd  out  5 each  registered indices (consumed by forwarding).
- load_use_stall  out  1  combinational; freezes PC and IF/ID this cycle.
- bubble_cnt, flush_cnt  out  PERF_CNT_W each  event counters (see Optional Feature).

Behaviour:
- Reset (rst=0, asynchronous): ex_valid=0; ex_ctrl all-zero; every other registered output and both counters = 0. load_use_stall=0 while in reset.
- Update priority each rising edge, highest first:
  1. stall_in=1: hold all registers. Flush and load-use are ignored; EX is also frozen and re-asserts flush after release.
  2. flush=1: load a bubble.
  3. load-use hazard: load a bubble.
  4. Otherwise: capture all id_* fields; ex_valid=id_valid.
- Bubble: ex_valid=0, ex_ctrl=0 (load_regfile, mem_read, mem_write all 0), all data/index fields=0.
- Operand usage is decoded from id_ctrl.opcode:
  - uses_rs1 = jalr, br, load, store, imm, reg, csr.
  - uses_rs2 = br, store, reg.
  - lui, auipc, jal use neither.
- Hazard condition, all terms must hold:
  - ex_valid and ex_ctrl.mem_read and ex_ctrl.load_regfile;
  - ex_rd != 0;
  - id_valid;
  - (uses_rs1 and id_rs1==ex_rd) or (uses_rs2 and id_rs2==ex_rd).
- Because op_csr sets mem_read, CSR reads are treated as loads.
- load_use_stall = hazard and !stall_in and !flush. Gated by flush because the younger instruction is being squashed anyway.
- Latency: one cycle id→ex. A load-use pair inserts exactly one bubble; the next cycle EX holds the bubble, the hazard clears, and the held decode instruction advances.
- Hazard against an x0 destination never fires. Store data dependency (rs2) on a load also stalls; no MEM→EX store forwarding is assumed.
- Reset asserted mid-stall or mid-bubble: outputs return to reset values immediately. No pending state survives.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined:
  - bubble_cnt increments by 1 on each edge where a load-use bubble is loaded.
  - flush_cnt increments by 1 on each edge where a flush bubble is loaded.
  - No increment while stall_in=1.
  - Both wrap from all-ones to 0; reset clears both.
- Undefined: both outputs tied to 0; no counter flops synthesized.

Test Plan:
- Reset: rst=0 with random inputs and clocks running → ex_valid=0, ex_ctrl=0, load_use_stall=0. Release → first capture occurs on the next edge.
- Plain advance: ADDI x5,x1,3 (id_pc=0x60, imm=3, id_valid=1) → next cycle ex_pc=0x60, ex_rd=5, ex_imm=3, ex_valid=1, load_use_stall=0.
- Load-use: EX holds LW x7 and ID presents ADD x8,x7,x2 → load_use_stall=1 for exactly one cycle; bubble enters EX (ex_valid=0); ADD reaches EX next edge; bubble_cnt 0→1 when the feature is enabled.
- Non-hazards: EX LW x0 with ID ADD x8,x0,x2, or EX LW x7 with ID LUI x7 → load_use_stall=0, no bubble.
- Flush vs hazard: flush=1 while a load-use hazard is present → load_use_stall=0, bubble loaded, flush_cnt+1, bubble_cnt unchanged.
- Stall priority: stall_in=1 for 3 cycles with flush=1 and a hazard present → EX outputs unchanged for all 3 edges, counters unchanged, load_use_stall=0.
